// File: rtl/constants_pkg.sv
// Shared bus constants and the OAM DMA sequencer state type.
package constants_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] HRAM_IO_BASE = 16'hFF00;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_controller_dma_bus_mux.sv
// Memory bus owner select and CPU blocking decode for the OAM DMA sequencer.
module dma_bus_mux
  import constants_pkg::*;
(
  input  oam_dma_state_t state,
  input  logic           restart,
  input  logic [7:0]     phase,
  input  logic [15:0]    src_address,
  input  logic [15:0]    dst_address,
  input  logic [7:0]     dma_byte,
  input  logic [15:0]    cpu_address,
  input  logic           cpu_RE,
  input  logic           cpu_WE,
  output logic [15:0]    mem_address,
  output logic           mem_RE,
  output logic           mem_WE,
  output logic [7:0]     mem_wdata,
  output logic           cpu_blocked
);

  logic cpu_access;
  logic hram_io;
  logic dma_active;

  assign cpu_access = cpu_RE | cpu_WE;
  assign hram_io    = (cpu_address >= HRAM_IO_BASE);
  // A restart cycle hands the bus back to the CPU so no partial slot access escapes.
  assign dma_active = (state == XFER) && !restart;
  assign mem_wdata  = dma_byte;

  always_comb begin
    mem_address = cpu_address;
    mem_RE      = cpu_RE;
    mem_WE      = cpu_WE;
    cpu_blocked = 1'b0;
    if (dma_active) begin
      if (phase < 8'd3) begin
        mem_RE      = 1'b0;
        mem_WE      = 1'b0;
        cpu_blocked = cpu_access;
        unique case (phase)
          8'd0: begin
            mem_address = src_address;
            mem_RE      = 1'b1;
          end
          8'd2: begin
            mem_address = dst_address;
            mem_WE      = 1'b1;
          end
          default: ;
        endcase
      end else if (!hram_io) begin
        mem_RE      = 1'b0;
        mem_WE      = 1'b0;
        cpu_blocked = cpu_access;
      end
    end
  end

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies OAM_BYTES bytes from page {src,00} to FE00 and arbitrates the bus.
// Optional macro OAM_DMA_CONFLICT_COUNT_EN adds a saturating count of blocked CPU cycles.
module oam_dma_controller
  import constants_pkg::*;
#(
  parameter int unsigned BYTE_CYCLES = 4,
  parameter int unsigned START_DELAY = 4,
  parameter int unsigned OAM_BYTES   = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_wr,
  input  logic [7:0]  dma_data,
  input  logic [15:0] cpu_address,
  input  logic        cpu_RE,
  input  logic        cpu_WE,
  output logic [15:0] mem_address,
  output logic        mem_RE,
  output logic        mem_WE,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        cpu_blocked,
  output logic        busy,
  output logic        done
`ifdef OAM_DMA_CONFLICT_COUNT_EN
  ,
  output logic [15:0] conflict_count
`endif
);

  oam_dma_state_t state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;

  logic       slot_end;
  logic       last_slot;
  logic [7:0] src_page;

  assign slot_end  = (phase_q == 8'(BYTE_CYCLES - 1));
  assign last_slot = (index_q == 8'(OAM_BYTES - 1));
  // Pages E0-FF alias the echo region onto C0-DF.
  assign src_page  = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      index_q <= 8'h00;
      phase_q <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    phase_d = phase_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (dma_wr) begin
      state_d = START;
      page_d  = dma_data;
      index_d = 8'h00;
      phase_d = 8'h00;
    end else begin
      unique case (state_q)
        IDLE: ;
        START: begin
          if (phase_q == 8'(START_DELAY - 1)) begin
            state_d = XFER;
            phase_d = 8'h00;
          end else begin
            phase_d = phase_q + 8'd1;
          end
        end
        XFER: begin
          if (phase_q == 8'd1) data_d = mem_rdata;
          if (slot_end) begin
            phase_d = 8'h00;
            if (last_slot) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              index_d = index_q + 8'd1;
            end
          end else begin
            phase_d = phase_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  dma_bus_mux u_bus_mux (
    .state       (state_q),
    .restart     (dma_wr),
    .phase       (phase_q),
    .src_address ({src_page, index_q}),
    .dst_address ({OAM_BASE[15:8], index_q}),
    .dma_byte    (data_q),
    .cpu_address (cpu_address),
    .cpu_RE      (cpu_RE),
    .cpu_WE      (cpu_WE),
    .mem_address (mem_address),
    .mem_RE      (mem_RE),
    .mem_WE      (mem_WE),
    .mem_wdata   (mem_wdata),
    .cpu_blocked (cpu_blocked)
  );

`ifdef OAM_DMA_CONFLICT_COUNT_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk) begin
    if (rst || dma_wr) begin
      conflict_q <= 16'h0000;
    end else if (cpu_blocked && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_count = conflict_q;
`endif

endmodule
